// File: rtl/oled_pkg.sv
// Shared state type, SSD1306 address-window header and frame sizes.
package oled_pkg;

  typedef enum logic [1:0] {
    OCIOSO,
    COMANDO,
    DADOS,
    FIM
  } estado_t;

  // Header: set column window 0..127, then page window 0..7
  localparam logic [7:0] CMD_COL = 8'h21;
  localparam logic [7:0] COL_INI = 8'h00;
  localparam logic [7:0] COL_FIM = 8'h7F;
  localparam logic [7:0] CMD_PAG = 8'h22;
  localparam logic [7:0] PAG_INI = 8'h00;
  localparam logic [7:0] PAG_FIM = 8'h07;

  localparam int N_CMD   = 6;
  localparam int N_BYTES = 1024;

  // Header byte for position idx (0..5)
  function automatic logic [7:0] cabecalho(input logic [2:0] idx);
    case (idx)
      3'd0:    cabecalho = CMD_COL;
      3'd1:    cabecalho = COL_INI;
      3'd2:    cabecalho = COL_FIM;
      3'd3:    cabecalho = CMD_PAG;
      3'd4:    cabecalho = PAG_INI;
      default: cabecalho = PAG_FIM;
    endcase
  endfunction

endpackage

// File: rtl/transmissor_oled_spi_if.sv
// Frame handshake plus the 4-wire SPI pins of the OLED transmitter.
interface transmissor_oled_spi_if;

  logic [oled_pkg::N_BYTES*8-1:0] imagem;
  logic                           iniciar;
  logic                           ocupado;
  logic                           pronto;
  logic                           sclk;
  logic                           mosi;
  logic                           cs_n;
  logic                           dc;

  // Upstream side (image controller / timer, display pins observed)
  modport master (
    output imagem, iniciar,
    input  ocupado, pronto, sclk, mosi, cs_n, dc
  );

  // Transmitter side
  modport slave (
    input  imagem, iniciar,
    output ocupado, pronto, sclk, mosi, cs_n, dc
  );

endinterface

// File: rtl/serializador_spi.sv
// SPI mode-0 byte serializer: MSB first, sclk low then high for DIV_CLK cycles each.
module serializador_spi #(
  parameter int DIV_CLK = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       carregar,
  input  logic [7:0] byte_in,
  output logic       sclk,
  output logic       mosi,
  output logic       byte_fim
);

  localparam int             DW      = (DIV_CLK > 1) ? $clog2(DIV_CLK) : 1;
  localparam logic [DW-1:0]  DIV_MAX = DW'(DIV_CLK - 1);

  logic [7:0]    shift_reg;
  logic [DW-1:0] div_reg;
  logic [2:0]    bit_reg;
  logic          sclk_reg;
  logic          ativo_reg;
  logic          fim_meio;

  // End of the current half-period
  assign fim_meio = ativo_reg && (div_reg == DIV_MAX);
  // Last sclk-high cycle of bit 7: the next load lands on the falling edge
  assign byte_fim = fim_meio && sclk_reg && (bit_reg == 3'd7);

  assign sclk = sclk_reg;
  assign mosi = shift_reg[7];

  // Shift register, half-period divider and bit counter
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_reg <= 8'h00;
      div_reg   <= '0;
      bit_reg   <= 3'd0;
      sclk_reg  <= 1'b0;
      ativo_reg <= 1'b0;
    end else if (carregar) begin
      shift_reg <= byte_in;
      div_reg   <= '0;
      bit_reg   <= 3'd0;
      sclk_reg  <= 1'b0;
      ativo_reg <= 1'b1;
    end else if (byte_fim) begin
      // No follow-on byte: park the link with sclk and mosi low
      shift_reg <= 8'h00;
      div_reg   <= '0;
      bit_reg   <= 3'd0;
      sclk_reg  <= 1'b0;
      ativo_reg <= 1'b0;
    end else if (fim_meio) begin
      div_reg  <= '0;
      sclk_reg <= ~sclk_reg;
      if (sclk_reg) begin
        shift_reg <= {shift_reg[6:0], 1'b0};
        bit_reg   <= bit_reg + 3'd1;
      end
    end else if (ativo_reg) begin
      div_reg <= div_reg + 1'b1;
    end
  end

endmodule

// File: rtl/transmissor_oled_spi.sv
// Sends a 6-byte address header plus the 1024-byte frame to the SSD1306 over SPI.
module transmissor_oled_spi
  import oled_pkg::*;
#(
  parameter int DIV_CLK = 4
) (
  input logic                   clk,
  input logic                   rst,
  transmissor_oled_spi_if.slave bus
);

  localparam logic [10:0] ULTIMO    = 11'(N_CMD + N_BYTES - 1);
  localparam logic [10:0] PRIM_DADO = 11'(N_CMD);

  estado_t     state_reg, state_next;
  logic [10:0] cnt_reg, cnt_next, prox;
  logic        dc_reg, dc_next;
  logic        carregar, byte_fim;
  logic [7:0]  byte_sel;
  logic [9:0]  dado_idx;

  assign prox     = cnt_reg + 11'd1;
  assign dado_idx = 10'(prox - PRIM_DADO);

  serializador_spi #(.DIV_CLK(DIV_CLK)) u_ser (
    .clk      (clk),
    .rst      (rst),
    .carregar (carregar),
    .byte_in  (byte_sel),
    .sclk     (bus.sclk),
    .mosi     (bus.mosi),
    .byte_fim (byte_fim)
  );

  assign bus.ocupado = (state_reg == COMANDO) || (state_reg == DADOS);
  assign bus.cs_n    = !((state_reg == COMANDO) || (state_reg == DADOS));
  assign bus.pronto  = (state_reg == FIM);
  assign bus.dc      = dc_reg;

  // State, byte counter and dc registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= OCIOSO;
      cnt_reg   <= 11'd0;
      dc_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      dc_reg    <= dc_next;
    end
  end

  // Next state and byte selection; dc updates together with each byte load
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    dc_next    = dc_reg;
    carregar   = 1'b0;
    byte_sel   = 8'h00;
    case (state_reg)
      OCIOSO: begin
        if (bus.iniciar) begin
          state_next = COMANDO;
          cnt_next   = 11'd0;
          dc_next    = 1'b0;
          carregar   = 1'b1;
          byte_sel   = cabecalho(3'd0);
        end
      end
      COMANDO, DADOS: begin
        if (byte_fim) begin
          if (cnt_reg == ULTIMO) begin
            state_next = FIM;
            cnt_next   = 11'd0;
            dc_next    = 1'b0;
          end else begin
            cnt_next = prox;
            carregar = 1'b1;
            if (prox < PRIM_DADO) begin
              dc_next  = 1'b0;
              byte_sel = cabecalho(prox[2:0]);
            end else begin
              state_next = DADOS;
              dc_next    = 1'b1;
              byte_sel   = bus.imagem[{dado_idx, 3'b000} +: 8];
            end
          end
        end
      end
      FIM: begin
        state_next = OCIOSO;
      end
      default: begin
        state_next = OCIOSO;
      end
    endcase
  end

endmodule

// File: tb/tb_transmissor_oled_spi.sv
// Directed bench: one DIV_CLK=1 instance for frame content/corner cases,
// one DIV_CLK=4 instance running a full frame in parallel for divider timing.
module tb_transmissor_oled_spi;
  import oled_pkg::*;

  typedef struct {
    int         idx;  // byte position inside the frame (0..5 = header)
    logic [7:0] val;
    logic       dc;
  } vec_t;

  logic clk;
  logic rst1, rst4;
  int   total = 0;
  int   bad   = 0;
  bit   done4 = 1'b0;

  transmissor_oled_spi_if bus1 ();
  transmissor_oled_spi_if bus4 ();

  transmissor_oled_spi #(.DIV_CLK(1)) dut1 (.clk(clk), .rst(rst1), .bus(bus1.slave));
  transmissor_oled_spi #(.DIV_CLK(4)) dut4 (.clk(clk), .rst(rst4), .bus(bus4.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  vec_t       tbl [12];
  logic [7:0] byte_q [$];
  logic       dc_q [$];
  int         cs_low, n_pronto, pronto_at, mosi_bad, dc_chg;
  logic       first_ok, fim_ok;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  function automatic logic [7:0] exp_byte(input int i, input int pat);
    if (pat == 0) return 8'(i);
    return 8'(i * 7 + 3);
  endfunction

  // Pulse iniciar on dut1, then sample every cycle (index 1 = cycle after acceptance edge)
  task automatic run1(input int max_cycles, input bit inject);
    logic       ps, pm, dcf;
    logic [7:0] sh;
    int         nb;
    byte_q.delete();
    dc_q.delete();
    cs_low = 0; n_pronto = 0; pronto_at = -1; mosi_bad = 0; dc_chg = 0;
    first_ok = 1'b0; fim_ok = 1'b0;
    ps = 1'b0; pm = 1'b0; dcf = 1'b0; sh = 8'h00; nb = 0;
    @(negedge clk);
    bus1.iniciar = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= max_cycles; k++) begin
      @(negedge clk);
      if (k == 1)
        first_ok = (bus1.cs_n === 1'b0) && (bus1.ocupado === 1'b1) && (bus1.dc === 1'b0)
                   && (bus1.mosi === 1'b0) && (bus1.sclk === 1'b0);
      if (bus1.cs_n === 1'b0) cs_low++;
      if (bus1.pronto === 1'b1) begin
        n_pronto++;
        if (pronto_at < 0) begin
          pronto_at = k;
          fim_ok = (bus1.cs_n === 1'b1) && (bus1.sclk === 1'b0) && (bus1.ocupado === 1'b0);
        end
      end
      if (k > 1 && bus1.mosi !== pm && !(ps === 1'b1 && bus1.sclk === 1'b0)) mosi_bad++;
      if (ps === 1'b0 && bus1.sclk === 1'b1) begin
        if (nb == 0) dcf = bus1.dc;
        else if (bus1.dc !== dcf) dc_chg++;
        sh = {sh[6:0], bus1.mosi};
        nb++;
        if (nb == 8) begin
          byte_q.push_back(sh);
          dc_q.push_back(dcf);
          nb = 0;
        end
      end
      ps = bus1.sclk;
      pm = bus1.mosi;
      // Stray starts: during data byte 100 and in the FIM cycle
      if (inject && (k == 16 * 106 + 5 || k == pronto_at)) bus1.iniciar = 1'b1;
      else bus1.iniciar = 1'b0;
    end
  endtask

  task automatic check_frame(input string tag, input int pat);
    int         errs;
    logic [7:0] gb;
    logic       gd;
    chk({tag, "_first_bit"}, first_ok, 1);
    chk({tag, "_cs_low_cycles"}, cs_low, 16480);
    chk({tag, "_pronto_count"}, n_pronto, 1);
    chk({tag, "_pronto_cycle"}, pronto_at, 16481);
    chk({tag, "_fim_outputs"}, fim_ok, 1);
    chk({tag, "_byte_count"}, byte_q.size(), 1030);
    chk({tag, "_mosi_stable"}, mosi_bad, 0);
    chk({tag, "_dc_in_byte"}, dc_chg, 0);
    for (int t = 0; t < 12; t++) begin
      if (pat == 0 || tbl[t].idx < N_CMD) begin
        gb = (tbl[t].idx < byte_q.size()) ? byte_q[tbl[t].idx] : 8'hxx;
        gd = (tbl[t].idx < dc_q.size()) ? dc_q[tbl[t].idx] : 1'bx;
        chk($sformatf("%s_byte%0d", tag, tbl[t].idx), gb, tbl[t].val);
        chk($sformatf("%s_dc%0d", tag, tbl[t].idx), gd, tbl[t].dc);
      end
    end
    errs = 0;
    for (int i = 0; i < N_BYTES; i++) begin
      if (i + N_CMD >= byte_q.size()) errs++;
      else if (byte_q[i + N_CMD] !== exp_byte(i, pat) || dc_q[i + N_CMD] !== 1'b1) errs++;
    end
    chk({tag, "_data_bytes_wrong"}, errs, 0);
  endtask

  // Main sequence on the DIV_CLK=1 instance
  initial begin : main_proc
    int viol;
    tbl[0]  = '{0,    8'h21, 1'b0};
    tbl[1]  = '{1,    8'h00, 1'b0};
    tbl[2]  = '{2,    8'h7F, 1'b0};
    tbl[3]  = '{3,    8'h22, 1'b0};
    tbl[4]  = '{4,    8'h00, 1'b0};
    tbl[5]  = '{5,    8'h07, 1'b0};
    tbl[6]  = '{6,    8'h00, 1'b1};
    tbl[7]  = '{7,    8'h01, 1'b1};
    tbl[8]  = '{106,  8'h64, 1'b1};
    tbl[9]  = '{261,  8'hFF, 1'b1};
    tbl[10] = '{262,  8'h00, 1'b1};
    tbl[11] = '{1029, 8'hFF, 1'b1};

    rst1 = 1'b1;
    bus1.iniciar = 1'b0;
    for (int i = 0; i < N_BYTES; i++) bus1.imagem[i*8 +: 8] = exp_byte(i, 0);
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("rst_cs_n", bus1.cs_n, 1);
    chk("rst_sclk", bus1.sclk, 0);
    chk("rst_mosi", bus1.mosi, 0);
    chk("rst_dc", bus1.dc, 0);
    chk("rst_ocupado", bus1.ocupado, 0);
    chk("rst_pronto", bus1.pronto, 0);
    rst1 = 1'b0;
    viol = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (bus1.cs_n !== 1'b1 || bus1.sclk !== 1'b0 || bus1.mosi !== 1'b0 ||
          bus1.ocupado !== 1'b0 || bus1.pronto !== 1'b0) viol++;
    end
    chk("idle_50_cycles", viol, 0);

    // A: clean full frame
    run1(16481 + 4, 1'b0);
    check_frame("A", 0);
    $display("frame A: bytes=%0d pronto_at=%0d", byte_q.size(), pronto_at);

    // B: stray starts mid-frame and in FIM
    run1(16481 + 8, 1'b1);
    check_frame("B", 0);
    chk("B_idle_after", bus1.ocupado, 0);
    $display("frame B: bytes=%0d pronto_count=%0d", byte_q.size(), n_pronto);

    // C: reset during data byte 500
    run1(16 * 506 + 3, 1'b0);
    chk("C_pre_reset_pronto", n_pronto, 0);
    chk("C_pre_reset_dc", bus1.dc, 1);
    rst1 = 1'b1;
    @(negedge clk);
    chk("C_rst_cs_n", bus1.cs_n, 1);
    chk("C_rst_sclk", bus1.sclk, 0);
    chk("C_rst_mosi", bus1.mosi, 0);
    chk("C_rst_dc", bus1.dc, 0);
    chk("C_rst_ocupado", bus1.ocupado, 0);
    chk("C_rst_pronto", bus1.pronto, 0);
    rst1 = 1'b0;
    viol = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (bus1.pronto !== 1'b0 || bus1.cs_n !== 1'b1) viol++;
    end
    chk("C_quiet_after_reset", viol, 0);
    $display("frame C: reset at data byte 500");

    // D: fresh frame with a different image
    for (int i = 0; i < N_BYTES; i++) bus1.imagem[i*8 +: 8] = exp_byte(i, 1);
    run1(16481 + 4, 1'b0);
    check_frame("D", 1);
    $display("frame D: bytes=%0d pronto_at=%0d", byte_q.size(), pronto_at);

    wait (done4);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // DIV_CLK=4 instance: phase widths, mosi stability, frame time
  initial begin : div4_proc
    logic       ps, pm;
    logic [7:0] sh;
    int         nb, run, bad_run, chg, cs4, p4, p4_at, errs;
    logic [7:0] q4 [$];
    rst4 = 1'b1;
    bus4.iniciar = 1'b0;
    for (int i = 0; i < N_BYTES; i++) bus4.imagem[i*8 +: 8] = 8'(255 - i);
    repeat (4) @(negedge clk);
    rst4 = 1'b0;
    @(negedge clk);
    bus4.iniciar = 1'b1;
    @(posedge clk);
    ps = 1'b0; pm = 1'b0; sh = 8'h00; nb = 0; run = 0; bad_run = 0; chg = 0;
    cs4 = 0; p4 = 0; p4_at = -1;
    for (int k = 1; k <= 65925; k++) begin
      @(negedge clk);
      bus4.iniciar = 1'b0;
      if (bus4.cs_n === 1'b0) cs4++;
      if (bus4.pronto === 1'b1) begin
        p4++;
        if (p4_at < 0) p4_at = k;
      end
      if (bus4.sclk === ps) run++;
      else begin
        if (run != 4) bad_run++;
        run = 1;
      end
      if (k > 1 && bus4.mosi !== pm && !(ps === 1'b1 && bus4.sclk === 1'b0)) chg++;
      if (ps === 1'b0 && bus4.sclk === 1'b1) begin
        sh = {sh[6:0], bus4.mosi};
        nb++;
        if (nb == 8) begin
          q4.push_back(sh);
          nb = 0;
        end
      end
      ps = bus4.sclk;
      pm = bus4.mosi;
    end
    chk("D4_cs_low_cycles", cs4, 65920);
    chk("D4_pronto_count", p4, 1);
    chk("D4_pronto_cycle", p4_at, 65921);
    chk("D4_phase_len_wrong", bad_run, 0);
    chk("D4_mosi_stable", chg, 0);
    chk("D4_byte_count", q4.size(), 1030);
    for (int t = 0; t < N_CMD; t++)
      chk($sformatf("D4_hdr%0d", t), (t < q4.size()) ? q4[t] : 8'hxx, tbl[t].val);
    errs = 0;
    for (int i = 0; i < N_BYTES; i++)
      if (i + N_CMD >= q4.size() || q4[i + N_CMD] !== 8'(255 - i)) errs++;
    chk("D4_data_bytes_wrong", errs, 0);
    $display("div4 frame: bytes=%0d cs_low=%0d pronto_at=%0d", q4.size(), cs4, p4_at);
    done4 = 1'b1;
  end

  initial begin : watchdog
    #1500000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "simulation did not finish");
  end

endmodule

// File: doc/transmissor_oled_spi.md
# transmissor_oled_spi

Consumes the 1024-byte frame produced by `controlador_imagens` and transmits it over a 4-wire SPI link to the 128x64 SSD1306 OLED. Each frame is sent as a 6-byte command header that resets the column and page address window, followed by the 1024 image bytes. It sits between the image controller and the display pins and is triggered once per frame refresh by the top-level timer.

## Interface
Parameters:
- `DIV_CLK`, 4 — SCLK half-period in `clk` cycles; minimum 1.

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  synchronous, active-high reset
- `imagem`  in  8192  frame; byte i = `imagem[i*8 +: 8]`, i = 0..1023
- `iniciar`  in  1  start pulse; accepted only when `ocupado`=0
- `ocupado`  out  1  high from the cycle after acceptance until frame end
- `pronto`  out  1  one-cycle pulse when the frame completes
- `sclk`  out  1  SPI clock, idle low (mode 0)
- `mosi`  out  1  SPI data, MSB first
- `cs_n`  out  1  chip select, active low
- `dc`  out  1  0 = command byte, 1 = data byte

## Operation
- States: OCIOSO, COMANDO, DADOS, FIM.
- OCIOSO:
  - `cs_n`=1, `sclk`=0, `mosi`=0, `dc`=0, `ocupado`=0.
  - `iniciar`=1 loads command byte 0 and enters COMANDO.
- COMANDO: sends 0x21, 0x00, 0x7F, 0x22, 0x00, 0x07 in that order with `dc`=0, then enters DADOS.
- DADOS:
  - Sends bytes 0..1023 with `dc`=1.
  - Byte i is sampled from `imagem` in the cycle it is loaded into the shift register.
  - Upstream keeps the frame stable while `ocupado`=1; tearing is otherwise accepted.
- FIM:
  - One cycle with `cs_n`=1, `pronto`=1, `ocupado`=0.
  - Returns to OCIOSO.
- The byte counter is 11 bits, counting 0..1029 across the header and data. There is no wrap-around; the state leaves DADOS at the count of 1029.
- `iniciar` is ignored while `ocupado`=1 and during FIM. A pulse in FIM is lost.
- `dc` changes only at byte boundaries, in the same cycle `mosi` takes the new byte's MSB.

## Timing
- Reset values: `cs_n`=1, `sclk`=0, `mosi`=0, `dc`=0, `ocupado`=0, `pronto`=0. State is OCIOSO and counters are 0.
- Reset mid-frame: all outputs take their reset values on the next edge. No `pronto` is issued.
- Acceptance and first bit:
  - `iniciar` is high at edge N.
  - At N+1: `cs_n`=0, `ocupado`=1, `dc`=0, `mosi`=bit 7 of 0x21, `sclk`=0.
- Bit timing:
  - Each bit lasts 2·`DIV_CLK` cycles: `sclk` low for `DIV_CLK` cycles, then high for `DIV_CLK` cycles.
  - `mosi` changes only when `sclk` falls (or at frame start), so it is stable through every rising edge.
- Bytes are back-to-back with no gap. `cs_n` stays low for the whole frame.
- Frame length:
  - `cs_n` is low for exactly 1030·16·`DIV_CLK` cycles.
  - At cycle N+1+1030·16·`DIV_CLK`: `cs_n`=1, `sclk`=0, `pronto`=1, `ocupado`=0.
- Earliest restart: `iniciar` may be accepted in the cycle after the `pronto` pulse.

## Structure
- Package `oled_pkg`:
  - state enum
  - header constants CMD_COL=0x21, COL_INI=0x00, COL_FIM=0x7F, CMD_PAG=0x22, PAG_INI=0x00, PAG_FIM=0x07
  - N_CMD=6, N_BYTES=1024
- Sub-module `serializador_spi`:
  - Contains the byte shift register, divider counter and bit counter.
  - Inputs: `carregar`, `byte_in`. Outputs: `sclk`, `mosi`, `byte_fim` (pulse on the last `sclk`-high cycle of a byte).
  - The top level holds the FSM, byte counter, `dc` and `cs_n`.

## Test plan
- Reset idle: hold `rst`, then idle 50 cycles -> `cs_n`=1, `sclk`=0, `mosi`=0, `ocupado`=0, no `pronto`.
- Header capture: `DIV_CLK`=1, pulse `iniciar` -> first 6 bytes sampled on `sclk` rising edges are 21 00 7F 22 00 07 with `dc`=0, and byte 6 has `dc`=1.
- Full frame: `imagem` byte i = i mod 256, `DIV_CLK`=1 -> 1024 data bytes match. `cs_n` is low for exactly 16480 cycles. `pronto` is a single pulse at N+16481.
- Divider: `DIV_CLK`=4 -> `sclk` high and low phases are each 4 cycles. `mosi` never changes while `sclk`=1. Frame time is 65920 cycles.
- Ignored start: pulse `iniciar` at byte 100 and in the FIM cycle -> no restart, exactly one `pronto`, and the next `iniciar` starts a fresh header.
- Reset mid-frame: assert `rst` during data byte 500 -> `cs_n`=1 next cycle, no `pronto`. A new `iniciar` produces a complete, correct frame.
